// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit for the multicycle MIPS datapath.
//   Implements mult, multu, div, divu (one bit per cycle, fixed 34-cycle
//   latency from the start edge to the done cycle) and mthi/mtlo writes.
//   ITER must equal WIDTH.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request, sampled only while idle
//   op           00 mult, 01 multu, 10 div, 11 divu
//   a, b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_wr, lo_wr mthi / mtlo strobes (idle only, start has priority)
//   wdata        data for mthi / mtlo
//   busy         high whenever the unit is not idle
//   done         one-cycle pulse, HI/LO valid from this cycle on
//   div_by_zero  high together with done when a divide had b == 0
//   hi, lo       HI / LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} state_t;

  localparam int CW = $clog2(ITER + 1);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  // Shared accumulator: MUL holds {partial product, remaining multiplier},
  // DIV holds {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic               is_div;
  logic               neg_lo;    // negate product / quotient at FIN
  logic               neg_hi;    // negate remainder at FIN (sign of dividend)
  logic               dbz;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand magnitudes for the signed ops; unsigned ops pass through.
  logic               signed_op, sign_a, sign_b, b_zero, last;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_op = ~op[0];
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;
  assign b_zero    = (b == {WIDTH{1'b0}});
  assign last      = (cnt == CW'(ITER - 1));

  // One iteration of shift-add and of restoring division.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  // Sign-corrected results written at FIN.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_nx    = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (!op[1])      state_nx = MUL;
        else if (b_zero) state_nx = DONE;
        else             state_nx = DIV;
      end
      MUL:  if (last) state_nx = FIN;
      DIV:  if (last) state_nx = FIN;
      FIN:  state_nx = DONE;
      DONE: begin
        done        = 1'b1;
        div_by_zero = dbz;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset as well so an aborted operation leaves
  // no stale state behind; there is no array storage here to worry about.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_lo <= sign_a ^ sign_b;
            neg_hi <= op[1] & sign_a;
            dbz    <= op[1] & b_zero;
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else begin
            if (hi_wr) hi_q <= wdata;
            if (lo_wr) lo_q <= wdata;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          // Keep the difference only when it did not borrow (restoring step).
          if (div_diff[WIDTH])
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          else
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. A behavioural model (plain 64-bit
//   arithmetic plus a latency countdown) predicts busy/done/div_by_zero/hi/lo
//   every cycle; directed cases pin the model with literal expectations, then
//   randomized operations with stray start/mthi/mtlo pulses follow.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an operation straight from the arithmetic definition:
  // {div_by_zero, hi, lo}.
  function automatic logic [64:0] model_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
    longint      sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin sp = sx * sy; return {1'b0, sp[63:0]}; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; return {1'b0, up}; end
      2'b10: begin
        if (y == 0) return {1'b1, 64'b0};
        sq = sx / sy;
        sr = sx % sy;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {1'b1, 64'b0};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Cycle-level model: m_rem counts cycles until idle (34 for a computation,
  // 1 for divide-by-zero); the done cycle is m_rem == 1.
  int          m_rem;
  logic        m_dz;
  logic [31:0] m_hi, m_lo, m_rh, m_rl;

  always @(posedge clock or negedge reset) begin : model
    logic [64:0] r;
    if (!reset) begin
      m_rem <= 0; m_dz <= 1'b0; m_hi <= '0; m_lo <= '0; m_rh <= '0; m_rl <= '0;
    end else if (m_rem == 0) begin
      if (start) begin
        r = model_result(op, a, b);
        if (r[64]) begin
          m_rem <= 1; m_dz <= 1'b1;
        end else begin
          m_rem <= 34; m_dz <= 1'b0; m_rh <= r[63:32]; m_rl <= r[31:0];
        end
      end else begin
        if (hi_wr) m_hi <= wdata;
        if (lo_wr) m_lo <= wdata;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2 && !m_dz) begin
        m_hi <= m_rh;
        m_lo <= m_rl;
      end
    end
  end

  always @(negedge clock) begin
    check("busy", 64'(busy), 64'(m_rem != 0));
    check("done", 64'(done), 64'(m_rem == 1));
    check("div_by_zero", 64'(div_by_zero), 64'((m_rem == 1) && m_dz));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation, optionally disturbing inputs while busy, and wait for
  // done. lat = cycles from the start edge to the done cycle (inclusive).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit disturb, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!done && lat < 60) begin
      if (disturb) begin
        start = ($urandom_range(0, 5) == 0);
        op    = 2'($urandom);
        hi_wr = ($urandom_range(0, 5) == 0);
        lo_wr = ($urandom_range(0, 5) == 0);
        wdata = $urandom;
      end
      tick();
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    tick();
  endtask

  task automatic write_hilo(input bit hw, input bit lw, input logic [31:0] d);
    hi_wr = hw; lo_wr = lw; wdata = d;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int lat, dones;

  initial begin
    // Reset state.
    #12;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // mult 7 * -3.
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, lat);
    check("mult_latency", 64'(lat), 64'd34);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("mult_m1_hi", 64'(hi), 64'd0);
    check("mult_m1_lo", 64'(lo), 64'd1);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    check("div_latency", 64'(lat), 64'd34);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    check("divu_lo", 64'(lo), 64'h7FFF_FFFC);
    check("divu_hi", 64'(hi), 64'd1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);

    // Divide by zero leaves HI/LO untouched.
    write_hilo(1'b1, 1'b0, 32'h1111);
    write_hilo(1'b0, 1'b1, 32'h2222);
    op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("dbz_done", 64'(done), 64'd1);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    tick();
    check("dbz_idle", 64'(busy), 64'd0);
    check("dbz_hi", 64'(hi), 64'h1111);
    check("dbz_lo", 64'(lo), 64'h2222);

    // mthi / mtlo in idle.
    write_hilo(1'b1, 1'b0, 32'hAAAA_0000);
    check("mthi", 64'(hi), 64'hAAAA_0000);
    write_hilo(1'b0, 1'b1, 32'h5555);
    check("mtlo", 64'(lo), 64'h5555);

    // Start together with lo_wr: the write is dropped; hi_wr while busy ignored;
    // a second start during MUL yields a single done pulse.
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; lo_wr = 1'b0;
    check("start_beats_mtlo", 64'(lo), 64'h5555);
    hi_wr = 1'b1; wdata = 32'hBEEF;
    tick();
    hi_wr = 1'b0;
    check("mthi_busy", 64'(hi), 64'hAAAA_0000);
    start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) dones++;
      tick();
    end
    check("single_done", 64'(dones), 64'd1);
    check("multu_6x7", 64'(lo), 64'd42);

    // Asynchronous reset mid-operation.
    op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    run_op(2'b00, 32'd3, 32'd4, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'd34);
    check("post_reset_hi", 64'(hi), 64'd0);
    check("post_reset_lo", 64'(lo), 64'd12);

    // Randomized operations and idle writes against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi_wr = $urandom_range(0, 1); lo_wr = $urandom_range(0, 1);
        start = ($urandom_range(0, 3) == 0);
        op = 2'($urandom); a = pick_operand(); b = pick_operand();
        wdata = $urandom;
        tick();
        hi_wr = 1'b0; lo_wr = 1'b0; start = 1'b0;
        for (int k = 0; k < 40 && busy; k++) tick();
      end else begin
        run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom), lat);
      end
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath. It implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits downstream of the A/B operand registers and consumes Aout (rs) and Bout (rt).
- Its HI/LO outputs feed the register-write-data mux for mfhi/mflo.
- The control unit starts an operation and waits in a stall state until done pulses.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_wr  in  1  mthi: load HI from wdata.
- lo_wr  in  1  mtlo: load LO from wdata.
- wdata  in  WIDTH  data for mthi/mtlo.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; HI/LO are valid from this cycle on.
- div_by_zero  out  1  high together with done when a div/divu had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, iteration counter = 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result reaches HI/LO.
- States: IDLE, MUL, DIV, FIN, DONE.
- IDLE:
  - At edge E0 with start = 1, latch a, b, op; counter = 0.
  - op 0x goes to MUL. op 1x goes to DIV, or to DONE with the div_by_zero flag set if b == 0.
- Signed ops (mult, div) work on magnitudes; the result sign is recorded at E0.
- MUL:
  - Shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Runs for ITER edges (E1..E32), then goes to FIN.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Runs for ITER edges (E1..E32), then goes to FIN.
- FIN:
  - At E33, apply sign correction and write HI/LO, then go to DONE.
  - mult/multu: {hi, lo} = full 64-bit product; two's complement when the signs differ (mult only).
  - div/divu: lo = quotient truncated toward zero, hi = remainder carrying the sign of the dividend.
  - -2^31 / -1 yields lo = 0x80000000, hi = 0. No trap.
- DONE:
  - done = 1 for exactly one cycle, then IDLE at the next edge.
  - Fixed latency: done is high in the cycle after E33, i.e. 34 cycles after the start edge.
- Divide by zero:
  - Goes E0 -> DONE, with done and div_by_zero high in the cycle after E0.
  - HI/LO unchanged.
- busy = 1 from the cycle after E0 through DONE inclusive.
- start while busy: ignored, no queueing.
- hi_wr/lo_wr:
  - Take effect at the next edge, only in IDLE; ignored while busy.
  - Both may be asserted in the same cycle.
  - If start = 1 in the same IDLE cycle, start wins and the write is dropped.
- a/b may change after E0 without affecting the operation in flight.
- hi/lo hold their value at all times except FIN writes, IDLE mthi/mtlo, and reset.

Test Plan:
- mult a = 7, b = 0xFFFFFFFD (-3): done 34 cycles after start, div_by_zero = 0; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for exactly 34 cycles.
- multu a = b = 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001. mult with the same operands: hi = 0, lo = 1.
- div a = 0xFFFFFFF9 (-7), b = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu with the same operands: lo = 0x7FFFFFFC, hi = 1. div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- div a = 5, b = 0 with hi/lo preset to 0x1111/0x2222: done and div_by_zero high 1 cycle after start; hi/lo still 0x1111/0x2222.
- mthi/mtlo corner cases:
  - mthi 0xAAAA0000 then mtlo 0x5555 in IDLE: hi/lo update next edge.
  - hi_wr asserted while busy: no effect.
  - start and lo_wr asserted together in IDLE: lo_wr dropped.
  - A second start during MUL: ignored; only one done pulse.
- Start a multu, assert reset low at cycle 10 (asynchronously, mid-cycle): busy, done, hi, lo go to 0 immediately. Release reset and issue a new mult 3 * 4: hi = 0, lo = 12 after 34 cycles.
